lbist_controller: RTL and testbench
===================================

// Module: lbist_controller
// PURPOSE
// - Sequences one logic-BIST session over a circuit-under-test (CUT).
// - For each of NUM_SEEDS seeds, in order:
//   - seeds the pattern LFSR;
//   - arms the MISR to hash a fixed number of CUT outputs;
//   - collects the MISR signature and compares it to the golden signature for that seed.
// - Reports a per-seed pass/fail bitmask to the host over val/rdy.
// - Sits between the host/JTAG request path and the lfsr/misr pair.
// PARAMETERS
// - NUM_SEEDS            4        number of seed/signature pairs per session (>=1)
// - SEED_BITS            32       LFSR seed width
// - SIGNATURE_BITS       32       MISR signature width
// - MAX_OUTPUTS_TO_HASH  32       upper bound on CUT outputs the MISR hashes per seed
// - LBIST_MSG_BITS       $clog2(MAX_OUTPUTS_TO_HASH)   MISR count field is LBIST_MSG_BITS+1 wide
// - NUM_OUTPUTS          MAX_OUTPUTS_TO_HASH   outputs hashed per seed (1..MAX_OUTPUTS_TO_HASH)
// - SEEDS                packed NUM_SEEDS*SEED_BITS; entry i at [i*SEED_BITS +: SEED_BITS]
// - EXPECTED_SIGNATURES  packed NUM_SEEDS*SIGNATURE_BITS; entry i likewise
// PORTS
// - clk             in   1                 clock
// - reset           in   1                 asynchronous, active-high reset
// - lbist_req_val   in   1                 host requests a session start
// - lbist_req_rdy   out  1                 controller idle, accepts start
// - lbist_resp_val  out  1                 session result valid
// - lbist_resp_msg  out  NUM_SEEDS         bit i = 1 when seed i signature matched
// - lbist_resp_rdy  in   1                 host accepts result
// - lfsr_req_val    out  1                 seed valid to LFSR
// - lfsr_req_msg    out  SEED_BITS         seed value
// - lfsr_req_rdy    in   1                 LFSR accepts seed
// - misr_req_val    out  1                 arm MISR
// - misr_req_msg    out  LBIST_MSG_BITS+1  number of outputs to hash (= NUM_OUTPUTS)
// - misr_req_rdy    in   1                 MISR accepts arm
// - misr_resp_val   in   1                 signature valid
// - misr_resp_msg   in   SIGNATURE_BITS    signature
// - misr_resp_rdy   out  1                 controller accepts signature
// BEHAVIOUR
// - States: IDLE, ARM, WAIT, DONE.
//   - Registers: seed index idx (clog2(NUM_SEEDS) bits, min 1); result mask; lfsr_sent, misr_sent flags.
// - Reset, asynchronous, takes effect immediately:
//   - state=IDLE; idx=0; mask=0; flags=0.
//   - All *_val outputs 0; misr_resp_rdy=0; lbist_resp_msg=0.
//   - lbist_req_rdy=0 while reset is high.
// - Reset mid-session: the session is abandoned and no response is produced.
//   - The MISR/LFSR are reset by the same signal.
// - IDLE:
//   - lbist_req_rdy=1.
//   - On lbist_req_val&&rdy: idx=0, mask=0, flags=0, go to ARM next cycle.
// - ARM:
//   - lfsr_req_val=!lfsr_sent, with msg=SEEDS[idx].
//   - misr_req_val=!misr_sent, with msg=NUM_OUTPUTS.
//   - The two handshakes are independent and may fire in the same cycle or in either order.
//   - Each sets its flag on fire. Once both have fired (flags, or a same-cycle fire), go to WAIT.
//   - Neither val drops before its own rdy is seen.
// - WAIT:
//   - misr_resp_rdy=1.
//   - On fire: mask[idx] = (misr_resp_msg == EXPECTED_SIGNATURES[idx]), full-width equality.
//   - If idx==NUM_SEEDS-1, go to DONE. Otherwise idx++, clear flags, go to ARM.
//   - misr_resp_val outside WAIT is ignored (rdy=0).
// - DONE:
//   - lbist_resp_val=1; lbist_resp_msg=mask, held stable until lbist_resp_rdy.
//   - On fire, go to IDLE. lbist_resp_msg stays at the last mask until the next session start.
// - lbist_req_val while not IDLE is not accepted (rdy=0).
// - Timing:
//   - All outputs are registered-state decodes. No combinational path from any *_rdy input to any *_val output.
//   - Minimum latency, start accept to lbist_resp_val: 2*NUM_SEEDS+1 cycles with all rdy=1 and zero-latency MISR response.
// - No timeout: a MISR that never responds stalls in WAIT; only reset recovers.
// STRUCTURE
// - lbist_pkg (shared):
//   - state enum lbist_ctrl_state_t {IDLE, ARM, WAIT, DONE};
//   - a function to slice packed parameter arrays.
// - Sub-module lbist_seed_rom:
//   - combinational lookup, idx -> {seed, expected signature}, from the packed parameters;
//   - reused later by a multi-CUT controller.
// - The FSM, counters, flags and mask stay in lbist_controller.
// TESTING
// - Bench parameters: NUM_SEEDS=2, SEEDS={32'h1234,32'hACE1}, EXPECTED={32'hCAFEF00D,32'hDEADBEEF}, NUM_OUTPUTS=16.
// - 1 All match: start; all rdy=1; MISR returns DEADBEEF then CAFEF00D.
//   -> lfsr msgs ACE1, 1234; misr msgs 16,16; lbist_resp_msg=2'b11; resp_val at cycle 5.
// - 2 Mismatch: second signature 32'hCAFEF00C.
//   -> resp_msg=2'b01; seed 1 still issued.
// - 3 Split handshakes: lfsr_req_rdy low for 3 cycles, misr_req_rdy high.
//   -> misr fires once, lfsr_req_val held with msg ACE1 until fire; no duplicate misr_req.
// - 4 Backpressure: lbist_resp_rdy low for 5 cycles.
//   -> resp_val/msg stable; new lbist_req_val ignored (req_rdy=0) until resp fires.
// - 5 Reset mid-WAIT: assert reset while waiting on seed 0.
//   -> all vals 0 immediately; after release, IDLE with req_rdy=1; no resp emitted.
// - 6 Stray misr_resp_val in IDLE/ARM.
//   -> misr_resp_rdy=0; mask unchanged; later session result correct.

Source files
------------

// File: rtl/lbist_pkg.sv
// Shared declarations for the logic-BIST controller family.
//   lbist_ctrl_state_t : session sequencer states
//   entry_lsb()        : LSB position of entry `index` inside a packed
//                        array of `width`-bit entries (entry 0 at bit 0)
package lbist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        WAIT,
        DONE
    } lbist_ctrl_state_t;

    function automatic int unsigned entry_lsb(input int unsigned index,
                                              input int unsigned width);
        return index * width;
    endfunction

endpackage

// File: rtl/lbist_seed_rom.sv
// Combinational seed / golden-signature lookup for one BIST session.
// Ports:
//   idx_i       in  seed index
//   seed_o      out LFSR seed for that index
//   signature_o out expected MISR signature for that index
// Indices at or beyond NUM_SEEDS return zero.
module lbist_seed_rom
    import lbist_pkg::*;
#(
    parameter int unsigned NUM_SEEDS = 4,
    parameter int unsigned SEED_BITS = 32,
    parameter int unsigned SIGNATURE_BITS = 32,
    parameter int unsigned IDX_BITS = 2,
    parameter logic [NUM_SEEDS*SEED_BITS-1:0] SEEDS = '0,
    parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] EXPECTED_SIGNATURES = '0
) (
    input  logic [IDX_BITS-1:0]       idx_i,
    output logic [SEED_BITS-1:0]      seed_o,
    output logic [SIGNATURE_BITS-1:0] signature_o
);

    logic [SEED_BITS-1:0]      seed_tbl [NUM_SEEDS];
    logic [SIGNATURE_BITS-1:0] sig_tbl  [NUM_SEEDS];

    // Unpack at elaboration time so the runtime lookup is a plain array index.
    for (genvar i = 0; i < NUM_SEEDS; i++) begin : g_unpack
        assign seed_tbl[i] = SEEDS[entry_lsb(i, SEED_BITS) +: SEED_BITS];
        assign sig_tbl[i]  = EXPECTED_SIGNATURES[entry_lsb(i, SIGNATURE_BITS) +: SIGNATURE_BITS];
    end

    always_comb begin
        seed_o      = '0;
        signature_o = '0;
        if (32'(idx_i) < NUM_SEEDS) begin
            seed_o      = seed_tbl[idx_i];
            signature_o = sig_tbl[idx_i];
        end
    end

endmodule

// File: rtl/lbist_controller.sv
// Logic-BIST session sequencer. For each seed in order: loads the LFSR seed,
// arms the MISR for NUM_OUTPUTS outputs, collects the signature and records
// a per-seed match bit. The final mask is returned to the host.
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   lbist_req_val/rdy               host session start
//   lbist_resp_val/rdy/msg          session result, bit i = seed i matched
//   lfsr_req_val/rdy/msg            seed to the pattern LFSR
//   misr_req_val/rdy/msg            arm MISR with count of outputs to hash
//   misr_resp_val/rdy/msg           signature from the MISR
module lbist_controller
    import lbist_pkg::*;
#(
    parameter int unsigned NUM_SEEDS = 4,
    parameter int unsigned SEED_BITS = 32,
    parameter int unsigned SIGNATURE_BITS = 32,
    parameter int unsigned MAX_OUTPUTS_TO_HASH = 32,
    parameter int unsigned LBIST_MSG_BITS = $clog2(MAX_OUTPUTS_TO_HASH),
    parameter int unsigned NUM_OUTPUTS = MAX_OUTPUTS_TO_HASH,
    parameter logic [NUM_SEEDS*SEED_BITS-1:0] SEEDS = '0,
    parameter logic [NUM_SEEDS*SIGNATURE_BITS-1:0] EXPECTED_SIGNATURES = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      lbist_req_val,
    output logic                      lbist_req_rdy,
    output logic                      lbist_resp_val,
    output logic [NUM_SEEDS-1:0]      lbist_resp_msg,
    input  logic                      lbist_resp_rdy,
    output logic                      lfsr_req_val,
    output logic [SEED_BITS-1:0]      lfsr_req_msg,
    input  logic                      lfsr_req_rdy,
    output logic                      misr_req_val,
    output logic [LBIST_MSG_BITS:0]   misr_req_msg,
    input  logic                      misr_req_rdy,
    input  logic                      misr_resp_val,
    input  logic [SIGNATURE_BITS-1:0] misr_resp_msg,
    output logic                      misr_resp_rdy
);

    localparam int unsigned IDX_BITS = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1;
    localparam int unsigned CNT_BITS = LBIST_MSG_BITS + 1;
    localparam logic [IDX_BITS-1:0] LAST_IDX   = IDX_BITS'(NUM_SEEDS - 1);
    localparam logic [CNT_BITS-1:0] HASH_COUNT = CNT_BITS'(NUM_OUTPUTS);

    lbist_ctrl_state_t         state_q, state_d;
    logic [IDX_BITS-1:0]       idx_q, idx_d;
    logic [NUM_SEEDS-1:0]      mask_q, mask_d;
    logic                      lfsr_sent_q, lfsr_sent_d;
    logic                      misr_sent_q, misr_sent_d;
    logic [SEED_BITS-1:0]      rom_seed;
    logic [SIGNATURE_BITS-1:0] rom_signature;
    logic                      lfsr_fire;
    logic                      misr_fire;

    lbist_seed_rom #(
        .NUM_SEEDS           (NUM_SEEDS),
        .SEED_BITS           (SEED_BITS),
        .SIGNATURE_BITS      (SIGNATURE_BITS),
        .IDX_BITS            (IDX_BITS),
        .SEEDS               (SEEDS),
        .EXPECTED_SIGNATURES (EXPECTED_SIGNATURES)
    ) u_seed_rom (
        .idx_i       (idx_q),
        .seed_o      (rom_seed),
        .signature_o (rom_signature)
    );

    // Every output is a decode of registered state; no rdy input reaches a val.
    assign lbist_req_rdy  = (state_q == IDLE) && !reset;
    assign lfsr_req_val   = (state_q == ARM) && !lfsr_sent_q;
    assign lfsr_req_msg   = rom_seed;
    assign misr_req_val   = (state_q == ARM) && !misr_sent_q;
    assign misr_req_msg   = HASH_COUNT;
    assign misr_resp_rdy  = (state_q == WAIT);
    assign lbist_resp_val = (state_q == DONE);
    // The mask persists after DONE until the next session start clears it.
    assign lbist_resp_msg = mask_q;

    assign lfsr_fire = lfsr_req_val && lfsr_req_rdy;
    assign misr_fire = misr_req_val && misr_req_rdy;

    always_comb begin
        // NOTE: every _d is given its hold value first so no branch below can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        mask_d      = mask_q;
        lfsr_sent_d = lfsr_sent_q;
        misr_sent_d = misr_sent_q;
        unique case (state_q)
            IDLE: begin
                if (lbist_req_val) begin
                    idx_d       = '0;
                    mask_d      = '0;
                    lfsr_sent_d = 1'b0;
                    misr_sent_d = 1'b0;
                    state_d     = ARM;
                end
            end
            ARM: begin
                // The two handshakes complete independently; a same-cycle
                // fire on both counts as done.
                lfsr_sent_d = lfsr_sent_q || lfsr_fire;
                misr_sent_d = misr_sent_q || misr_fire;
                if ((lfsr_sent_q || lfsr_fire) && (misr_sent_q || misr_fire)) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (misr_resp_val) begin
                    mask_d[idx_q] = (misr_resp_msg == rom_signature);
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d       = idx_q + IDX_BITS'(1);
                        lfsr_sent_d = 1'b0;
                        misr_sent_d = 1'b0;
                        state_d     = ARM;
                    end
                end
            end
            DONE: begin
                if (lbist_resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            lfsr_sent_q <= 1'b0;
            misr_sent_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            idx_q       <= idx_d;
            mask_q      <= mask_d;
            lfsr_sent_q <= lfsr_sent_d;
            misr_sent_q <= misr_sent_d;
        end
    end

endmodule

// File: tb/tb_lbist_controller.sv
// Scoreboard bench for lbist_controller (2 seeds, 16 outputs per seed).
// Stimulus pushes the expected seeds, arm counts and result mask into queues;
// a monitor process pops and compares whenever the DUT fires a handshake and
// also plays the MISR, returning queued signatures after a random delay.
module tb_lbist_controller;

    localparam logic [63:0] SEEDS_P = 64'h0000_1234_0000_ACE1;
    localparam logic [63:0] EXP_P   = 64'hCAFE_F00D_DEAD_BEEF;
    localparam logic [31:0] SEED_TBL [2] = '{32'h0000_ACE1, 32'h0000_1234};
    localparam logic [31:0] SIG_TBL  [2] = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    localparam logic [5:0]  HASH_N = 6'd16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        lbist_req_val = 1'b0;
    logic        lbist_req_rdy;
    logic        lbist_resp_val;
    logic [1:0]  lbist_resp_msg;
    logic        lbist_resp_rdy = 1'b1;
    logic        lfsr_req_val;
    logic [31:0] lfsr_req_msg;
    logic        lfsr_req_rdy = 1'b1;
    logic        misr_req_val;
    logic [5:0]  misr_req_msg;
    logic        misr_req_rdy = 1'b1;
    logic        misr_resp_val = 1'b0;
    logic [31:0] misr_resp_msg = '0;
    logic        misr_resp_rdy;

    always #5 clk = ~clk;

    lbist_controller #(
        .NUM_SEEDS           (2),
        .SEED_BITS           (32),
        .SIGNATURE_BITS      (32),
        .MAX_OUTPUTS_TO_HASH (32),
        .NUM_OUTPUTS         (16),
        .SEEDS               (SEEDS_P),
        .EXPECTED_SIGNATURES (EXP_P)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .lbist_req_val  (lbist_req_val),
        .lbist_req_rdy  (lbist_req_rdy),
        .lbist_resp_val (lbist_resp_val),
        .lbist_resp_msg (lbist_resp_msg),
        .lbist_resp_rdy (lbist_resp_rdy),
        .lfsr_req_val   (lfsr_req_val),
        .lfsr_req_msg   (lfsr_req_msg),
        .lfsr_req_rdy   (lfsr_req_rdy),
        .misr_req_val   (misr_req_val),
        .misr_req_msg   (misr_req_msg),
        .misr_req_rdy   (misr_req_rdy),
        .misr_resp_val  (misr_resp_val),
        .misr_resp_msg  (misr_resp_msg),
        .misr_resp_rdy  (misr_resp_rdy)
    );

    typedef struct {
        logic [31:0] sig;
        int unsigned delay;
    } pend_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] sig_q[$];
    logic [31:0] exp_lfsr_q[$];
    logic [5:0]  exp_arm_q[$];
    logic [1:0]  exp_resp_q[$];
    pend_t       pend_q[$];

    int unsigned misr_lat_max = 0;
    bit          misr_hold = 1'b0;
    bit          stray_en = 1'b0;
    logic [1:0]  last_mask = 2'b00;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] actual);
        checks++;
        errors++;
        $display("FAIL %s: unexpected handshake carrying %0h at %0t", name, actual, $time);
    endtask

    task automatic finish_bench();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // Monitor + MISR model
    bit          resp_fire_seen = 1'b0;
    bit          stray_active = 1'b0;
    bit          prev_lfsr_hold = 1'b0;
    bit          prev_arm_hold = 1'b0;
    bit          prev_resp_hold = 1'b0;
    logic [31:0] prev_lfsr_msg = '0;
    logic [5:0]  prev_arm_msg = '0;
    logic [1:0]  prev_resp_msg = '0;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_lfsr_hold = 1'b0;
                prev_arm_hold  = 1'b0;
                prev_resp_hold = 1'b0;
                resp_fire_seen = 1'b0;
            end else begin
                if (prev_lfsr_hold) begin
                    check("lfsr_val_held", 64'(lfsr_req_val), 64'd1);
                    check("lfsr_msg_held", 64'(lfsr_req_msg), 64'(prev_lfsr_msg));
                end
                if (prev_arm_hold) begin
                    check("misr_req_val_held", 64'(misr_req_val), 64'd1);
                    check("misr_req_msg_held", 64'(misr_req_msg), 64'(prev_arm_msg));
                end
                if (prev_resp_hold) begin
                    check("resp_val_held", 64'(lbist_resp_val), 64'd1);
                    check("resp_msg_held", 64'(lbist_resp_msg), 64'(prev_resp_msg));
                end
                if (lfsr_req_val && lfsr_req_rdy) begin
                    if (exp_lfsr_q.size() > 0) check("lfsr_seed", 64'(lfsr_req_msg), 64'(exp_lfsr_q.pop_front()));
                    else unexpected("lfsr_req", 64'(lfsr_req_msg));
                end
                if (misr_req_val && misr_req_rdy) begin
                    if (exp_arm_q.size() > 0 && sig_q.size() > 0) begin
                        check("misr_arm_count", 64'(misr_req_msg), 64'(exp_arm_q.pop_front()));
                        pend_q.push_back('{sig: sig_q.pop_front(),
                                           delay: misr_hold ? 32'd1000 : $urandom_range(0, misr_lat_max)});
                    end else begin
                        unexpected("misr_req", 64'(misr_req_msg));
                    end
                end
                if (misr_resp_val && misr_resp_rdy) resp_fire_seen = 1'b1;
                if (lbist_resp_val && lbist_resp_rdy) begin
                    if (exp_resp_q.size() > 0) check("resp_mask", 64'(lbist_resp_msg), 64'(exp_resp_q.pop_front()));
                    else unexpected("lbist_resp", 64'(lbist_resp_msg));
                end
                prev_lfsr_hold = lfsr_req_val && !lfsr_req_rdy;
                prev_lfsr_msg  = lfsr_req_msg;
                prev_arm_hold  = misr_req_val && !misr_req_rdy;
                prev_arm_msg   = misr_req_msg;
                prev_resp_hold = lbist_resp_val && !lbist_resp_rdy;
                prev_resp_msg  = lbist_resp_msg;
            end

            @(posedge clk);
            #1;
            if (reset) begin
                misr_resp_val = 1'b0;
                stray_active  = 1'b0;
                pend_q.delete();
            end else begin
                if (resp_fire_seen) begin
                    misr_resp_val  = 1'b0;
                    resp_fire_seen = 1'b0;
                end
                if (pend_q.size() > 0 && (!misr_resp_val || stray_active)) begin
                    if (stray_active) begin
                        misr_resp_val = 1'b0;
                        stray_active  = 1'b0;
                    end
                    if (pend_q[0].delay > 0) begin
                        pend_q[0].delay = pend_q[0].delay - 1;
                    end else begin
                        misr_resp_val = 1'b1;
                        misr_resp_msg = pend_q[0].sig;
                        void'(pend_q.pop_front());
                    end
                end else if (pend_q.size() == 0 && (!misr_resp_val || stray_active)) begin
                    misr_resp_val = stray_en;
                    stray_active  = stray_en;
                    if (stray_en) misr_resp_msg = $urandom();
                end
            end
        end
    end

    // Reference model: per-seed match bit is plain equality with the golden table.
    task automatic start_session(input logic [31:0] sig0, input logic [31:0] sig1);
        logic [1:0] m;
        int n;
        m[0] = (sig0 == SIG_TBL[0]);
        m[1] = (sig1 == SIG_TBL[1]);
        sig_q.push_back(sig0);
        sig_q.push_back(sig1);
        for (int i = 0; i < 2; i++) begin
            exp_lfsr_q.push_back(SEED_TBL[i]);
            exp_arm_q.push_back(HASH_N);
        end
        exp_resp_q.push_back(m);
        last_mask = m;
        @(posedge clk);
        #1;
        lbist_req_val = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (lbist_req_rdy) break;
            n++;
            if (n > 100) begin
                unexpected("start_accept_timeout", 64'(n));
                finish_bench();
            end
        end
        @(posedge clk);
        #1;
        lbist_req_val = 1'b0;
    endtask

    task automatic wait_drained(input int budget);
        int n;
        n = 0;
        while (exp_resp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_resp_q.size() != 0) begin
            unexpected("session_timeout", 64'(n));
            finish_bench();
        end
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        logic [31:0] s0, s1;

        #1;
        check("rst_req_rdy", 64'(lbist_req_rdy), 64'd0);
        check("rst_lfsr_val", 64'(lfsr_req_val), 64'd0);
        check("rst_misr_val", 64'(misr_req_val), 64'd0);
        check("rst_resp_val", 64'(lbist_resp_val), 64'd0);
        check("rst_resp_msg", 64'(lbist_resp_msg), 64'd0);
        check("rst_misr_resp_rdy", 64'(misr_resp_rdy), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_req_rdy", 64'(lbist_req_rdy), 64'd1);

        // All match, zero-latency MISR; also measure start-to-result latency.
        start_session(32'hDEAD_BEEF, 32'hCAFE_F00D);
        n = 1;
        while (!lbist_resp_val && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_cycles", 64'(n), 64'd5);
        wait_drained(50);

        // Second signature off by one bit.
        start_session(32'hDEAD_BEEF, 32'hCAFE_F00C);
        wait_drained(50);

        // LFSR stalls 3 cycles while the MISR arms immediately.
        lfsr_req_rdy = 1'b0;
        start_session(32'hDEAD_BEEF, 32'hCAFE_F00D);
        repeat (3) @(posedge clk);
        #1;
        lfsr_req_rdy = 1'b1;
        wait_drained(50);

        // Result backpressure with a competing start request.
        lbist_resp_rdy = 1'b0;
        start_session(32'hDEAD_BEEF, 32'hCAFE_F00D);
        n = 0;
        while (!lbist_resp_val && n < 50) begin
            @(negedge clk);
            n++;
        end
        lbist_req_val = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("busy_req_rdy", 64'(lbist_req_rdy), 64'd0);
            check("bp_resp_val", 64'(lbist_resp_val), 64'd1);
        end
        lbist_req_val  = 1'b0;
        lbist_resp_rdy = 1'b1;
        wait_drained(50);

        // Stray MISR responses in IDLE and ARM are ignored.
        stray_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("stray_idle_rdy", 64'(misr_resp_rdy), 64'd0);
            check("stray_idle_mask", 64'(lbist_resp_msg), 64'(last_mask));
        end
        lfsr_req_rdy = 1'b0;
        misr_req_rdy = 1'b0;
        start_session(32'h1234_5678, 32'hCAFE_F00D);
        repeat (3) begin
            @(negedge clk);
            check("stray_arm_rdy", 64'(misr_resp_rdy), 64'd0);
            check("stray_arm_lfsr_val", 64'(lfsr_req_val), 64'd1);
        end
        stray_en = 1'b0;
        @(posedge clk);
        #1;
        lfsr_req_rdy = 1'b1;
        misr_req_rdy = 1'b1;
        wait_drained(50);

        // Reset while waiting on the seed 0 signature.
        misr_hold = 1'b1;
        start_session(32'hDEAD_BEEF, 32'hCAFE_F00D);
        n = 0;
        while (exp_arm_q.size() != 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check("midwait_rdy", 64'(misr_resp_rdy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_lfsr_val", 64'(lfsr_req_val), 64'd0);
        check("midrst_misr_val", 64'(misr_req_val), 64'd0);
        check("midrst_resp_val", 64'(lbist_resp_val), 64'd0);
        check("midrst_misr_resp_rdy", 64'(misr_resp_rdy), 64'd0);
        check("midrst_req_rdy", 64'(lbist_req_rdy), 64'd0);
        exp_lfsr_q.delete();
        exp_arm_q.delete();
        exp_resp_q.delete();
        sig_q.delete();
        last_mask = 2'b00;
        misr_hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("post_rst_req_rdy", 64'(lbist_req_rdy), 64'd1);
        check("post_rst_resp_msg", 64'(lbist_resp_msg), 64'd0);
        repeat (10) @(negedge clk);
        check("post_rst_no_resp", 64'(lbist_resp_val), 64'd0);

        // Randomized sessions with random backpressure and MISR latency.
        misr_lat_max = 3;
        for (int s = 0; s < 25; s++) begin
            s0 = ($urandom_range(0, 1) == 1) ? SIG_TBL[0] : $urandom();
            s1 = ($urandom_range(0, 1) == 1) ? SIG_TBL[1] : $urandom();
            start_session(s0, s1);
            n = 0;
            while (exp_resp_q.size() != 0 && n < 300) begin
                @(posedge clk);
                #1;
                lfsr_req_rdy   = ($urandom_range(0, 3) != 0);
                misr_req_rdy   = ($urandom_range(0, 3) != 0);
                lbist_resp_rdy = ($urandom_range(0, 3) != 0);
                n++;
            end
            lfsr_req_rdy   = 1'b1;
            misr_req_rdy   = 1'b1;
            lbist_resp_rdy = 1'b1;
            wait_drained(50);
        end

        repeat (3) @(negedge clk);
        finish_bench();
    end

endmodule
